// File: rtl/trng_postproc.sv
// TRNG post-processor: synchronises and decimates the raw entropy bit, runs a
// repetition-count health test, Von Neumann debiases and packs words for valid/ready.
module trng_postproc #(
    parameter int OUT_W      = 32,
    parameter int SAMPLE_DIV = 4,
    parameter int RCT_CUTOFF = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_raw,
    input  logic             i_ready,
    input  logic             i_clr_alarm,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_alarm,
    output logic             o_overrun
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(OUT_W);
    localparam int RCT_W = $clog2(RCT_CUTOFF + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);
    localparam logic [RCT_W-1:0] RCT_MAX  = RCT_W'(RCT_CUTOFF);

    localparam logic [0:0] ST_EMPTY      = 1'b0;
    localparam logic [0:0] ST_HAVE_FIRST = 1'b1;

    logic             s1_q, s1_d, s2_q, s2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [0:0]       state_q, state_d;
    logic             first_q, first_d;
    logic             prev_q, prev_d;
    logic [RCT_W-1:0] rct_q, rct_d;
    logic [OUT_W-2:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             alarm_q, alarm_d;
    logic             overrun_q, overrun_d;

    logic             strobe_s;
    logic             trip_s;
    logic             block_s;
    logic             emit_s;
    logic             bit_s;
    logic             free_s;
    logic [RCT_W-1:0] rct_inc_s;
    logic [OUT_W-1:0] acc_shift_s;

    // Saturating run length: restart at 1 on a change, stop counting at the cutoff.
    function automatic logic [RCT_W-1:0] rct_step(input logic [RCT_W-1:0] cnt,
                                                  input logic             same);
        logic [RCT_W-1:0] r;
        if (!same) begin
            r = RCT_W'(1);
        end else if (cnt >= RCT_MAX) begin
            r = RCT_MAX;
        end else begin
            r = cnt + RCT_W'(1);
        end
        return r;
    endfunction

    // Synchroniser, sample divider and repetition-count health test.
    always_comb begin
        s1_d      = i_raw;
        s2_d      = s1_q;
        strobe_s  = i_en && (div_q == DIV_LAST);
        rct_inc_s = rct_step(rct_q, s2_q == prev_q);
        trip_s    = strobe_s && (rct_inc_s == RCT_MAX);
        prev_d    = strobe_s ? s2_q : prev_q;
        if (!i_en || strobe_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if (!i_en || i_clr_alarm) begin
            rct_d = '0;
        end else if (strobe_s) begin
            rct_d = rct_inc_s;
        end else begin
            rct_d = rct_q;
        end
        // A trip on the clearing edge must not be lost.
        if (trip_s) begin
            alarm_d = 1'b1;
        end else if (i_clr_alarm) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end
    end

    // Von Neumann pair FSM: 10 -> 1, 01 -> 0, equal pairs discarded.
    always_comb begin
        block_s = alarm_q || trip_s;
        state_d = state_q;
        first_d = first_q;
        emit_s  = 1'b0;
        bit_s   = first_q;
        if (!i_en || block_s) begin
            state_d = ST_EMPTY;
        end else if (strobe_s) begin
            case (state_q)
                ST_EMPTY: begin
                    first_d = s2_q;
                    state_d = ST_HAVE_FIRST;
                end
                ST_HAVE_FIRST: begin
                    emit_s  = (first_q != s2_q);
                    state_d = ST_EMPTY;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Word packing and output handshake; a full output with no taker drops bits.
    always_comb begin
        free_s      = !valid_q || i_ready;
        acc_shift_s = {acc_q, bit_s};
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = valid_q && !i_ready;
        overrun_d   = i_clr_alarm ? 1'b0 : overrun_q;
        if (block_s) begin
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (emit_s) begin
            if (cnt_q != CNT_LAST) begin
                acc_d = acc_shift_s[OUT_W-2:0];
                cnt_d = cnt_q + CNT_W'(1);
            end else if (free_s) begin
                data_d  = acc_shift_s;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            div_q     <= '0;
            state_q   <= ST_EMPTY;
            first_q   <= 1'b0;
            prev_q    <= 1'b0;
            rct_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            alarm_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            div_q     <= div_d;
            state_q   <= state_d;
            first_q   <= first_d;
            prev_q    <= prev_d;
            rct_q     <= rct_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            alarm_q   <= alarm_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_alarm   = alarm_q;
    assign o_overrun = overrun_q;

endmodule
